dsp_mac_mchan: RTL and testbench

- Parametrised multi-channel multiply-accumulate slice; next generation of the single-channel DSP slice.
- Keeps a signed A×B multiplier, an optional M pipeline register and a post-adder/subtracter.
- Adds NCH independent time-interleaved accumulators, saturation with sticky per-channel overflow, a valid/last streaming handshake, and a global clock enable.
- Sits between sample-stream producers (filters, correlators) and result consumers.

---
 rtl/dsp_mac_pkg.sv | 27 ++
 rtl/dsp_mac_mchan_if.sv | 31 +++
 rtl/dsp_mac_satadd.sv | 29 ++
 rtl/dsp_mac_mchan.sv | 144 ++++++++++++++
 tb/tb_dsp_mac_mchan.sv | 243 ++++++++++++++++++++++++
 5 files changed

// File: rtl/dsp_mac_pkg.sv
// Shared helpers and types for the multi-channel MAC slice.
package dsp_mac_pkg;

    localparam int CH_MAXW = 8;

    function automatic int clog2_min1(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    // Limits are returned wide and truncated to PW by the caller.
    function automatic logic [127:0] max_pos(input int pw);
        return (128'(1) << (pw - 1)) - 128'(1);
    endfunction

    function automatic logic [127:0] max_neg(input int pw);
        return 128'(1) << (pw - 1);
    endfunction

    typedef struct packed {
        logic [CH_MAXW-1:0] ch;
        logic               clr;
        logic               sub;
        logic               last;
        logic               valid;
    } ctrl_t;

endpackage

// File: rtl/dsp_mac_mchan_if.sv
// Sample-in / result-out bus of the multi-channel MAC slice.
interface dsp_mac_mchan_if #(
    parameter int AW  = 18,
    parameter int BW  = 18,
    parameter int PW  = 48,
    parameter int CHW = 2
);
    logic                  IN_VALID;
    logic [CHW-1:0]        IN_CH;
    logic                  IN_CLR;
    logic                  IN_SUB;
    logic                  IN_LAST;
    logic signed [AW-1:0]  A;
    logic signed [BW-1:0]  B;
    logic signed [PW-1:0]  C;
    logic                  OUT_VALID;
    logic [CHW-1:0]        OUT_CH;
    logic signed [PW-1:0]  P;
    logic                  OVF;
    logic                  ERR;

    modport master (
        output IN_VALID, IN_CH, IN_CLR, IN_SUB, IN_LAST, A, B, C,
        input  OUT_VALID, OUT_CH, P, OVF, ERR
    );

    modport slave (
        input  IN_VALID, IN_CH, IN_CLR, IN_SUB, IN_LAST, A, B, C,
        output OUT_VALID, OUT_CH, P, OVF, ERR
    );
endinterface

// File: rtl/dsp_mac_satadd.sv
// PW+1-bit add/subtract with overflow detect and optional clamp to the PW range.
module dsp_mac_satadd
    import dsp_mac_pkg::*;
#(
    parameter int PW       = 48,
    parameter bit SATURATE = 1'b1
) (
    input  logic signed [PW-1:0] base,
    input  logic signed [PW-1:0] prod,
    input  logic                 sub,
    output logic signed [PW-1:0] result,
    output logic                 ovf_now
);
    localparam logic [PW-1:0] MAX_POS = PW'(max_pos(PW));
    localparam logic [PW-1:0] MAX_NEG = PW'(max_neg(PW));

    logic signed [PW:0] sum;

    always_comb begin
        sum     = sub ? ({base[PW-1], base} - {prod[PW-1], prod})
                      : ({base[PW-1], base} + {prod[PW-1], prod});
        ovf_now = sum[PW] ^ sum[PW-1];
        if (SATURATE && ovf_now) begin
            result = sum[PW] ? MAX_NEG : MAX_POS;
        end else begin
            result = sum[PW-1:0];
        end
    end
endmodule

// File: rtl/dsp_mac_mchan.sv
// Multi-channel signed MAC: input register, optional product register, and a
// time-interleaved accumulator bank with saturation and sticky overflow.
module dsp_mac_mchan
    import dsp_mac_pkg::*;
#(
    parameter int AW       = 18,
    parameter int BW       = 18,
    parameter int PW       = 48,
    parameter int NCH      = 4,
    parameter bit MREG     = 1'b1,
    parameter bit SATURATE = 1'b1
) (
    input  logic        CLK,
    input  logic        RSTN,
    input  logic        CE,
    dsp_mac_mchan_if.slave bus
);
    localparam int          CHW   = clog2_min1(NCH);
    localparam int unsigned NCH_U = NCH;

    if (PW < AW + BW) begin : g_pw_check
        $error("dsp_mac_mchan: PW must be at least AW+BW");
    end
    if (NCH < 1 || CHW > CH_MAXW) begin : g_nch_check
        $error("dsp_mac_mchan: NCH out of supported range");
    end

    logic signed [AW-1:0]    a1;
    logic signed [BW-1:0]    b1;
    logic signed [PW-1:0]    c1;
    ctrl_t                   ctl1;
    logic signed [AW+BW-1:0] prod_full;
    logic signed [PW-1:0]    prod_ext;
    logic signed [PW-1:0]    prod_s;
    logic signed [PW-1:0]    c_s;
    ctrl_t                   ctl_s;

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            a1   <= '0;
            b1   <= '0;
            c1   <= '0;
            ctl1 <= '0;
        end else if (CE) begin
            a1   <= bus.A;
            b1   <= bus.B;
            c1   <= bus.C;
            ctl1 <= '{ch: CH_MAXW'(bus.IN_CH), clr: bus.IN_CLR, sub: bus.IN_SUB,
                      last: bus.IN_LAST, valid: bus.IN_VALID};
        end
    end

    assign prod_full = a1 * b1;
    assign prod_ext  = PW'(prod_full);

    if (MREG) begin : g_mreg
        logic signed [PW-1:0] prod_q;
        logic signed [PW-1:0] c_q;
        ctrl_t                ctl_q;

        always_ff @(posedge CLK or negedge RSTN) begin
            if (!RSTN) begin
                prod_q <= '0;
                c_q    <= '0;
                ctl_q  <= '0;
            end else if (CE) begin
                prod_q <= prod_ext;
                c_q    <= c1;
                ctl_q  <= ctl1;
            end
        end
        assign prod_s = prod_q;
        assign c_s    = c_q;
        assign ctl_s  = ctl_q;
    end else begin : g_no_mreg
        assign prod_s = prod_ext;
        assign c_s    = c1;
        assign ctl_s  = ctl1;
    end

    logic signed [PW-1:0] acc [NCH];
    logic [NCH-1:0]       ovf_q;
    logic signed [PW-1:0] acc_rd, base, result, p_q;
    logic                 ovf_rd, ovf_now, ovf_new, in_range;
    logic                 out_valid_q, ovf_out_q, err_q;
    logic [CHW-1:0]       ch_q;

    // Read and write of acc[ch] share this stage, so same-channel samples need no bypass.
    always_comb begin
        acc_rd = '0;
        ovf_rd = 1'b0;
        for (int unsigned i = 0; i < NCH_U; i++) begin
            if (32'(ctl_s.ch) == i) begin
                acc_rd = acc[i];
                ovf_rd = ovf_q[i];
            end
        end
        in_range = 32'(ctl_s.ch) < NCH_U;
        base     = ctl_s.clr ? c_s : acc_rd;
        ovf_new  = (ovf_rd & ~ctl_s.clr) | ovf_now;
    end

    dsp_mac_satadd #(.PW(PW), .SATURATE(SATURATE)) u_satadd (
        .base    (base),
        .prod    (prod_s),
        .sub     (ctl_s.sub),
        .result  (result),
        .ovf_now (ovf_now)
    );

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            for (int unsigned i = 0; i < NCH_U; i++) acc[i] <= '0;
            ovf_q       <= '0;
            p_q         <= '0;
            ch_q        <= '0;
            ovf_out_q   <= 1'b0;
            out_valid_q <= 1'b0;
            err_q       <= 1'b0;
        end else if (CE) begin
            out_valid_q <= ctl_s.valid & ctl_s.last & in_range;
            err_q       <= ctl_s.valid & ~in_range;
            if (ctl_s.valid && in_range) begin
                for (int unsigned i = 0; i < NCH_U; i++) begin
                    if (32'(ctl_s.ch) == i) begin
                        acc[i]   <= result;
                        ovf_q[i] <= ovf_new;
                    end
                end
                if (ctl_s.last) begin
                    p_q       <= result;
                    ovf_out_q <= ovf_new;
                    ch_q      <= ctl_s.ch[CHW-1:0];
                end
            end
        end
    end

    assign bus.OUT_VALID = out_valid_q;
    assign bus.OUT_CH    = ch_q;
    assign bus.P         = p_q;
    assign bus.OVF       = ovf_out_q;
    assign bus.ERR       = err_q;
endmodule

// File: tb/tb_dsp_mac_mchan.sv
// Bench for dsp_mac_mchan: four parameter variants driven by one stimulus stream,
// each checked against its own reference model through a result scoreboard.
module tb_dsp_mac_mchan;
    logic clk = 1'b0;
    logic rstn = 1'b0;
    logic ce = 1'b1;
    logic in_valid = 1'b0, in_clr = 1'b0, in_sub = 1'b0, in_last = 1'b0;
    logic [1:0] in_ch = '0;
    logic signed [17:0] in_a = '0, in_b = '0;
    logic signed [47:0] in_c = '0;
    logic [89:0] stim;

    always #5 clk = ~clk;

    dsp_mac_mchan_if #(.AW(18), .BW(18), .PW(48), .CHW(2)) if0(), if1(), if2(), if3();

    assign stim = {in_valid, in_ch, in_clr, in_sub, in_last, in_a, in_b, in_c};
    assign {if0.IN_VALID, if0.IN_CH, if0.IN_CLR, if0.IN_SUB, if0.IN_LAST, if0.A, if0.B, if0.C} = stim;
    assign {if1.IN_VALID, if1.IN_CH, if1.IN_CLR, if1.IN_SUB, if1.IN_LAST, if1.A, if1.B, if1.C} = stim;
    assign {if2.IN_VALID, if2.IN_CH, if2.IN_CLR, if2.IN_SUB, if2.IN_LAST, if2.A, if2.B, if2.C} = stim;
    assign {if3.IN_VALID, if3.IN_CH, if3.IN_CLR, if3.IN_SUB, if3.IN_LAST, if3.A, if3.B, if3.C} = stim;

    dsp_mac_mchan #(.AW(18), .BW(18), .PW(48), .NCH(4), .MREG(1'b1), .SATURATE(1'b1))
        dut0 (.CLK(clk), .RSTN(rstn), .CE(ce), .bus(if0));
    dsp_mac_mchan #(.AW(18), .BW(18), .PW(48), .NCH(4), .MREG(1'b0), .SATURATE(1'b1))
        dut1 (.CLK(clk), .RSTN(rstn), .CE(ce), .bus(if1));
    dsp_mac_mchan #(.AW(18), .BW(18), .PW(48), .NCH(4), .MREG(1'b1), .SATURATE(1'b0))
        dut2 (.CLK(clk), .RSTN(rstn), .CE(ce), .bus(if2));
    dsp_mac_mchan #(.AW(18), .BW(18), .PW(48), .NCH(3), .MREG(1'b0), .SATURATE(1'b1))
        dut3 (.CLK(clk), .RSTN(rstn), .CE(ce), .bus(if3));

    typedef struct {
        bit          err;
        logic [1:0]  ch;
        logic [47:0] p;
        bit          ovf;
        int unsigned cyc;
    } exp_t;

    exp_t        sb [4][$];
    int unsigned lat [4] = '{3, 2, 3, 2};
    bit          sat [4] = '{1'b1, 1'b1, 1'b0, 1'b1};
    int unsigned nch [4] = '{4, 4, 4, 3};
    logic [47:0] acc_m [4][4];
    bit          ovf_m [4][4];
    int          n_chk = 0;
    int          n_fail = 0;
    int unsigned ce_cyc = 0;

    always @(posedge clk) if (rstn && ce) ce_cyc <= ce_cyc + 1;

    task automatic chk(input string tag, input int d, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s dut%0d observed=%0h expected=%0h", tag, d, obs, exp);
        end
    endtask

    task automatic mon(input int d, input logic ov, input logic er, input logic [1:0] ch,
                       input logic [47:0] p, input logic ovf);
        exp_t e;
        if (ov !== 1'b0 || er !== 1'b0) begin
            chk("sb_pending", d, 64'(sb[d].size() != 0), 64'd1);
            if (sb[d].size() != 0) begin
                e = sb[d].pop_front();
                chk("kind", d, {62'd0, ov, er}, {62'd0, ~e.err, e.err});
                chk("latency", d, 64'(ce_cyc - e.cyc), 64'(lat[d]));
                if (!e.err) begin
                    chk("P", d, {16'd0, p}, {16'd0, e.p});
                    chk("OUT_CH", d, {62'd0, ch}, {62'd0, e.ch});
                    chk("OVF", d, {63'd0, ovf}, {63'd0, e.ovf});
                end
            end
        end
    endtask

    always @(negedge clk) if (rstn && ce) mon(0, if0.OUT_VALID, if0.ERR, if0.OUT_CH, if0.P, if0.OVF);
    always @(negedge clk) if (rstn && ce) mon(1, if1.OUT_VALID, if1.ERR, if1.OUT_CH, if1.P, if1.OVF);
    always @(negedge clk) if (rstn && ce) mon(2, if2.OUT_VALID, if2.ERR, if2.OUT_CH, if2.P, if2.OVF);
    always @(negedge clk) if (rstn && ce) mon(3, if3.OUT_VALID, if3.ERR, if3.OUT_CH, if3.P, if3.OVF);

    task automatic model(input int d, input logic [1:0] ch, input bit clr, input bit sub, input bit last,
                         input logic signed [17:0] a, input logic signed [17:0] b, input logic [47:0] c);
        logic signed [35:0] pr;
        logic signed [48:0] prx, bs, sum;
        logic [47:0] res;
        bit ov;
        exp_t e;
        pr  = a * b;
        prx = 49'(pr);
        bs  = clr ? $signed({c[47], c}) : $signed({acc_m[d][ch][47], acc_m[d][ch]});
        sum = sub ? bs - prx : bs + prx;
        ov  = sum[48] ^ sum[47];
        res = (sat[d] && ov) ? (sum[48] ? 48'h8000_0000_0000 : 48'h7fff_ffff_ffff) : sum[47:0];
        e.cyc = ce_cyc;
        e.ch  = ch;
        e.p   = res;
        if (32'(ch) >= nch[d]) begin
            e.err = 1'b1;
            e.ovf = 1'b0;
            sb[d].push_back(e);
        end else begin
            acc_m[d][ch] = res;
            ovf_m[d][ch] = (clr ? 1'b0 : ovf_m[d][ch]) | ov;
            if (last) begin
                e.err = 1'b0;
                e.ovf = ovf_m[d][ch];
                sb[d].push_back(e);
            end
        end
    endtask

    task automatic reset_model();
        for (int d = 0; d < 4; d++) begin
            sb[d].delete();
            for (int k = 0; k < 4; k++) begin
                acc_m[d][k] = '0;
                ovf_m[d][k] = 1'b0;
            end
        end
    endtask

    task automatic send(input logic [1:0] ch, input bit clr, input bit sub, input bit last,
                        input logic signed [17:0] a, input logic signed [17:0] b, input logic [47:0] c);
        @(posedge clk);
        #1;
        in_valid = 1'b1; in_ch = ch; in_clr = clr; in_sub = sub; in_last = last;
        in_a = a; in_b = b; in_c = c;
        for (int d = 0; d < 4; d++) model(d, ch, clr, sub, last, a, b, c);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            in_valid = 1'b0;
            in_last  = 1'($urandom_range(0, 1));
            in_clr   = 1'($urandom_range(0, 1));
            in_ch    = 2'($urandom_range(0, 3));
            in_a     = 18'($urandom());
        end
    endtask

    task automatic chk_zero(input int d, input logic ov, input logic er, input logic [1:0] ch,
                            input logic [47:0] p, input logic ovf);
        chk("rst_OUT_VALID", d, {63'd0, ov}, 64'd0);
        chk("rst_ERR", d, {63'd0, er}, 64'd0);
        chk("rst_OUT_CH", d, {62'd0, ch}, 64'd0);
        chk("rst_P", d, {16'd0, p}, 64'd0);
        chk("rst_OVF", d, {63'd0, ovf}, 64'd0);
    endtask

    task automatic chk_all_zero();
        chk_zero(0, if0.OUT_VALID, if0.ERR, if0.OUT_CH, if0.P, if0.OVF);
        chk_zero(1, if1.OUT_VALID, if1.ERR, if1.OUT_CH, if1.P, if1.OVF);
        chk_zero(2, if2.OUT_VALID, if2.ERR, if2.OUT_CH, if2.P, if2.OVF);
        chk_zero(3, if3.OUT_VALID, if3.ERR, if3.OUT_CH, if3.P, if3.OVF);
    endtask

    initial begin
        reset_model();
        #12;
        chk_all_zero();
        @(negedge clk) rstn = 1'b1;
        idle(2);

        // single-sample CLR+LAST: 5 + 3*4 = 17
        send(2'd0, 1'b1, 1'b0, 1'b1, 18'sd3, 18'sd4, 48'd5);
        idle(4);

        // interleaved channels: ch1 -> -24, ch2 -> 100
        for (int i = 0; i < 4; i++) begin
            send(2'd1, i == 0, 1'b0, i == 3, 18'sd2, -18'sd3, 48'd0);
            send(2'd2, i == 0, 1'b0, i == 3, 18'sd5, 18'sd5, 48'd0);
        end
        idle(3);

        // back-to-back same channel, no stall
        send(2'd3, 1'b1, 1'b0, 1'b0, 18'sd10, 18'sd10, 48'd1);
        send(2'd3, 1'b0, 1'b1, 1'b1, 18'sd3, 18'sd3, 48'd0);
        idle(3);

        // saturation, sticky flag, flag cleared by CLR
        send(2'd0, 1'b1, 1'b0, 1'b1, 18'sd4, 18'sd4, 48'h7fff_ffff_fff6);
        send(2'd0, 1'b0, 1'b0, 1'b1, 18'sd0, 18'sd0, 48'd0);
        send(2'd0, 1'b1, 1'b0, 1'b1, 18'sd1, 18'sd1, 48'd0);
        idle(3);

        // negative saturation
        send(2'd1, 1'b1, 1'b1, 1'b1, 18'sd131071, 18'sd131071, 48'h8000_0000_0005);
        idle(3);

        // subtract 100 - 42 = 58, then CE low for 5 cycles mid-pipeline
        send(2'd1, 1'b1, 1'b1, 1'b1, 18'sd7, 18'sd6, 48'd100);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        ce = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        ce = 1'b1;
        idle(5);

        // channel 3: error on the NCH=3 variant, normal accumulate elsewhere
        send(2'd3, 1'b1, 1'b0, 1'b1, 18'sd2, 18'sd2, 48'd0);
        send(2'd2, 1'b0, 1'b0, 1'b1, 18'sd1, 18'sd1, 48'd0);
        idle(4);

        for (int i = 0; i < 24; i++) begin
            if ($urandom_range(0, 3) == 0) idle(1);
            else send(2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                      1'($urandom_range(0, 1)), 18'($urandom()), 18'($urandom()),
                      48'({$urandom(), $urandom()}));
        end
        idle(5);

        // asynchronous reset between edges with samples in flight
        send(2'd0, 1'b1, 1'b0, 1'b1, 18'sd1, 18'sd1, 48'd1);
        send(2'd1, 1'b1, 1'b0, 1'b1, 18'sd2, 18'sd2, 48'd2);
        send(2'd2, 1'b1, 1'b0, 1'b1, 18'sd3, 18'sd3, 48'd3);
        #3;
        rstn = 1'b0;
        in_valid = 1'b0;
        #2;
        chk_all_zero();
        reset_model();
        @(negedge clk);
        @(negedge clk) rstn = 1'b1;
        idle(8);
        send(2'd0, 1'b1, 1'b0, 1'b1, 18'sd3, 18'sd4, 48'd5);
        idle(1);

        for (int i = 0; i < 60; i++) begin
            if (sb[0].size() == 0 && sb[1].size() == 0 && sb[2].size() == 0 && sb[3].size() == 0) break;
            @(posedge clk);
        end
        for (int d = 0; d < 4; d++) chk("drain", d, 64'(sb[d].size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
